// File: rtl/vga_buffer_arbiter_pkg.sv
// Shared constants, grant encodings and address helpers for the pixel
// buffer arbiter. The image geometry is shared with the VGA controller.
package vga_buffer_arbiter_pkg;

    localparam int IMAGE_WIDTH  = 320;
    localparam int IMAGE_HEIGHT = 240;
    localparam int PIX_W        = 12;
    localparam int ADDR_W       = 17;
    localparam int ROW_W        = 8;
    localparam int COL_W        = 9;
    localparam int DIV          = 4;
    localparam int FIFO_DEPTH   = 4;
    localparam int PHASE_W      = $clog2(DIV);
    localparam int LEVEL_W      = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_RD   = 2'd1,
        G_WR   = 2'd2
    } grant_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  pixel;
    } wr_entry_t;

    // Linear buffer address; operands widened first so nothing truncates.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
        return ADDR_W'(row) * ADDR_W'(IMAGE_WIDTH) + ADDR_W'(col);
    endfunction

    function automatic logic in_image(input logic [ROW_W-1:0] row,
                                      input logic [COL_W-1:0] col);
        return (int'(row) < IMAGE_HEIGHT) && (int'(col) < IMAGE_WIDTH);
    endfunction

endpackage

// File: rtl/vga_buffer_arbiter_if.sv
// Bus bundle between the arbiter, the VGA read path, the masking engine
// and the buffer RAM.
//
// Write handshake: a transfer happens on a rising clk edge where both
// wr_valid and wr_ready are 1. wr_valid must not depend on wr_ready; the
// write fields are held stable while wr_valid is 1 and wr_ready is 0.
interface vga_buffer_arbiter_if;
    import vga_buffer_arbiter_pkg::*;

    logic               disp_active;
    logic [ROW_W-1:0]   disp_row;
    logic [COL_W-1:0]   disp_col;
    logic [PIX_W-1:0]   disp_pixel;
    logic               wr_valid;
    logic               wr_ready;
    logic [ROW_W-1:0]   wr_row;
    logic [COL_W-1:0]   wr_col;
    logic [PIX_W-1:0]   wr_pixel;
    logic [ADDR_W-1:0]  ram_addr;
    logic               ram_we;
    logic [PIX_W-1:0]   ram_wdata;
    logic [PIX_W-1:0]   ram_rdata;
    logic [LEVEL_W-1:0] fifo_level;
    logic               oob_err;
    grant_e             grant;      // debug view of the grant state register

    modport slave (
        input  disp_active, disp_row, disp_col, wr_valid, wr_row, wr_col,
               wr_pixel, ram_rdata,
        output disp_pixel, wr_ready, ram_addr, ram_we, ram_wdata,
               fifo_level, oob_err, grant
    );

    modport master (
        output disp_active, disp_row, disp_col, wr_valid, wr_row, wr_col,
               wr_pixel, ram_rdata,
        input  disp_pixel, wr_ready, ram_addr, ram_we, ram_wdata,
               fifo_level, oob_err, grant
    );

endinterface

// File: rtl/arb_write_fifo.sv
// Small synchronous FIFO holding pending masking-engine writes.
// The caller never pushes when full or pops when empty.
module arb_write_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       pop_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;

    // Occupancy next state: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Entry storage; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Pointers and occupancy; a reset discards every queued entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign level_o    = count_q;

endmodule

// File: rtl/vga_buffer_arbiter.sv
// Pixel buffer arbiter: a phase-0 slot of every DIV-cycle frame belongs to
// the display read path; all other slots drain the queued masking writes.
module vga_buffer_arbiter
    import vga_buffer_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    vga_buffer_arbiter_if.slave bus
);
    logic [PHASE_W-1:0] phase_q, phase_d;
    grant_e             grant_q, grant_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic               ram_we_q, ram_we_d;
    logic [PIX_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [PIX_W-1:0]   disp_pixel_q, disp_pixel_d;
    logic               rd_pend_q;
    logic               ready_en_q;
    logic               oob_err_q;

    logic               wr_ready;
    logic               wr_in_range;
    logic               accept;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    wr_entry_t          push_entry;
    wr_entry_t          head;

    // Ready only once out of reset, and never bypassed by a same-cycle pop.
    assign wr_ready    = ready_en_q && !fifo_full;
    assign wr_in_range = in_image(bus.wr_row, bus.wr_col);
    assign accept      = bus.wr_valid && wr_ready;
    assign push        = accept && wr_in_range;
    assign pop         = (grant_d == G_WR);
    assign push_entry  = '{addr: pix_addr(bus.wr_row, bus.wr_col), pixel: bus.wr_pixel};

    arb_write_fifo #(
        .WIDTH ($bits(wr_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (bus.fifo_level)
    );

    // Free-running slot phase; wraps at DIV-1 and never stalls.
    always_comb begin
        phase_d = phase_q + PHASE_W'(1);
        if (phase_q == PHASE_W'(DIV - 1)) phase_d = '0;
    end

    // Grant decision and next RAM command: display read wins phase 0.
    always_comb begin
        grant_d     = G_NONE;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        if (phase_q == '0 && bus.disp_active) begin
            grant_d    = G_RD;
            ram_addr_d = pix_addr(bus.disp_row, bus.disp_col);
        end else if (!fifo_empty) begin
            grant_d     = G_WR;
            ram_addr_d  = head.addr;
            ram_we_d    = 1'b1;
            ram_wdata_d = head.pixel;
        end
    end

    // Display capture: take RAM data the cycle after the read slot, or
    // force black at phase 1 when the frame had no read.
    always_comb begin
        disp_pixel_d = disp_pixel_q;
        if (rd_pend_q) begin
            disp_pixel_d = bus.ram_rdata;
        end else if (phase_q == PHASE_W'(1) && grant_q != G_RD) begin
            disp_pixel_d = '0;
        end
    end

    // State and output registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q      <= '0;
            grant_q      <= G_NONE;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= '0;
            disp_pixel_q <= '0;
            rd_pend_q    <= 1'b0;
            ready_en_q   <= 1'b0;
            oob_err_q    <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            grant_q      <= grant_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            disp_pixel_q <= disp_pixel_d;
            rd_pend_q    <= (grant_q == G_RD);
            ready_en_q   <= 1'b1;
            if (accept && !wr_in_range) oob_err_q <= 1'b1;
        end
    end

    assign bus.wr_ready   = wr_ready;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.disp_pixel = disp_pixel_q;
    assign bus.oob_err    = oob_err_q;
    assign bus.grant      = grant_q;

endmodule

// File: tb/tb_vga_buffer_arbiter.sv
// Directed bench for the pixel buffer arbiter with a behavioural RAM.
module tb_vga_buffer_arbiter;
    import vga_buffer_arbiter_pkg::*;

    localparam int EXP_W = ADDR_W + PIX_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_buffer_arbiter_if bus ();

    vga_buffer_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_cnt  = 0;
    logic [1:0] tb_phase;
    bit   log_we [0:1023];
    logic [PIX_W-1:0] mem [0:IMAGE_WIDTH*IMAGE_HEIGHT-1];
    logic [EXP_W-1:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Synchronous single-port RAM, one cycle read latency.
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    // Reference slot phase and cycle index.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_phase <= 2'd0;
        else     tb_phase <= tb_phase + 2'd1;
    end
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Write monitor: every RAM write must match the next expected entry.
    always @(negedge clk) begin
        if (cyc_cnt < 1024) log_we[cyc_cnt] <= bus.ram_we;
        if (!rst && bus.ram_we) begin
            check_eq("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check_eq("wr_addr", 32'(bus.ram_addr), 32'(exp_q[0][EXP_W-1:PIX_W]));
                check_eq("wr_data", 32'(bus.ram_wdata), 32'(exp_q[0][PIX_W-1:0]));
                exp_q.delete(0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int count_we(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) n += int'(log_we[i]);
        return n;
    endfunction

    task automatic wait_phase(input int p);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (int'(tb_phase) == p) break;
        end
    endtask

    // Starts and ends on a falling edge; returns cycles spent stalled.
    task automatic send_write(input int row, input int col, input logic [PIX_W-1:0] pix,
                              output int waited);
        bus.wr_valid = 1'b1;
        bus.wr_row   = ROW_W'(row);
        bus.wr_col   = COL_W'(col);
        bus.wr_pixel = pix;
        waited = 0;
        while (!bus.wr_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (bus.wr_ready && row < IMAGE_HEIGHT && col < IMAGE_WIDTH)
            exp_q.push_back({ADDR_W'(row * IMAGE_WIDTH + col), pix});
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        int w;
        int k;
        rst = 1'b1;
        bus.disp_active = 1'b0;
        bus.disp_row = '0;
        bus.disp_col = '0;
        bus.wr_valid = 1'b0;
        bus.wr_row = '0;
        bus.wr_col = '0;
        bus.wr_pixel = '0;

        // Reset values and release.
        #12;
        check_eq("rst_ram_we", 32'(bus.ram_we), 0);
        check_eq("rst_ram_addr", 32'(bus.ram_addr), 0);
        check_eq("rst_level", 32'(bus.fifo_level), 0);
        check_eq("rst_pixel", 32'(bus.disp_pixel), 0);
        check_eq("rst_ready", 32'(bus.wr_ready), 0);
        check_eq("rst_oob", 32'(bus.oob_err), 0);
        #1 rst = 1'b0;
        #1 check_eq("ready_before_edge", 32'(bus.wr_ready), 0);
        @(negedge clk);
        check_eq("ready_after_edge", 32'(bus.wr_ready), 1);

        // Preload pixel (5,7) through the write path during blanking.
        send_write(5, 7, 12'hABC, w);
        check_eq("preload_wait", 32'(w), 0);
        repeat (4) @(negedge clk);

        // Display read of (5,7).
        wait_phase(3);
        bus.disp_active = 1'b1;
        bus.disp_row = 8'd5;
        bus.disp_col = 9'd7;
        @(negedge clk);
        @(negedge clk);
        check_eq("rd_addr", 32'(bus.ram_addr), 32'd1607);
        check_eq("rd_we", 32'(bus.ram_we), 0);
        bus.disp_active = 1'b0;
        @(negedge clk);
        check_eq("rd_pix_early", 32'(bus.disp_pixel), 0);
        @(negedge clk);
        check_eq("rd_pix", 32'(bus.disp_pixel), 32'hABC);
        @(negedge clk);
        check_eq("rd_pix_hold", 32'(bus.disp_pixel), 32'hABC);
        @(negedge clk);
        check_eq("blank_pix_ph1", 32'(bus.disp_pixel), 32'hABC);
        @(negedge clk);
        check_eq("blank_pix_ph2", 32'(bus.disp_pixel), 0);

        // Write stream against active display: 3 write slots per frame.
        wait_phase(0);
        k = cyc_cnt;
        bus.disp_active = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            if (c == 14) begin
                check_eq("full_level", 32'(bus.fifo_level), 4);
                check_eq("full_ready", 32'(bus.wr_ready), 0);
            end
            send_write(0, c, 12'(256 + c), w);
            check_eq("prio_wait", 32'(w), (c == 14) ? 32'd1 : 32'd0);
            if (c == 14) begin
                check_eq("pop_level", 32'(bus.fifo_level), 3);
                check_eq("pop_ready", 32'(bus.wr_ready), 1);
            end
        end
        check_eq("refull_level", 32'(bus.fifo_level), 4);
        check_eq("refull_ready", 32'(bus.wr_ready), 0);
        repeat (6) @(negedge clk);
        check_eq("win0", 32'(count_we(k + 1, k + 4)), 3);
        check_eq("win1", 32'(count_we(k + 5, k + 8)), 3);
        check_eq("win2", 32'(count_we(k + 9, k + 12)), 3);
        check_eq("win3", 32'(count_we(k + 13, k + 16)), 3);
        check_eq("win4", 32'(count_we(k + 17, k + 20)), 3);
        check_eq("prio_total", 32'(count_we(k, k + 22)), 16);
        for (int s = 0; s < 6; s++)
            check_eq("rd_slot_we", 32'(log_we[k + 1 + 4 * s]), 0);
        check_eq("mem_c1", 32'(mem[1]), 32'h101);
        check_eq("mem_c8", 32'(mem[8]), 32'h108);
        check_eq("mem_c16", 32'(mem[16]), 32'h110);
        check_eq("prio_drained", 32'(exp_q.size()), 0);

        // Blanking: one write per cycle after a single fill cycle.
        wait_phase(0);
        k = cyc_cnt;
        check_eq("blank_hold", 32'(bus.disp_pixel), 32'hABC);
        bus.disp_active = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_write(1, 20 + i, 12'(512 + i), w);
            check_eq("blank_wait", 32'(w), 0);
        end
        check_eq("blank_pix", 32'(bus.disp_pixel), 0);
        repeat (3) @(negedge clk);
        check_eq("blank_fill", 32'(log_we[k + 1]), 0);
        check_eq("blank_burst", 32'(count_we(k + 2, k + 9)), 8);
        check_eq("blank_after", 32'(log_we[k + 10]), 0);
        check_eq("mem_347", 32'(mem[347]), 32'h207);
        check_eq("blank_drained", 32'(exp_q.size()), 0);

        // Out-of-range write is accepted and dropped; flag is sticky.
        send_write(240, 0, 12'hFFF, w);
        check_eq("oob_wait", 32'(w), 0);
        check_eq("oob_level", 32'(bus.fifo_level), 0);
        check_eq("oob_set", 32'(bus.oob_err), 1);
        repeat (3) @(negedge clk);
        check_eq("oob_sticky", 32'(bus.oob_err), 1);
        send_write(239, 319, 12'h5A5, w);
        repeat (4) @(negedge clk);
        check_eq("mem_last", 32'(mem[76799]), 32'h5A5);
        check_eq("oob_sticky2", 32'(bus.oob_err), 1);
        check_eq("oob_drained", 32'(exp_q.size()), 0);

        // Reset mid-stream with three writes queued.
        wait_phase(0);
        bus.disp_active = 1'b1;
        for (int c = 0; c < 16; c++) send_write(2, c, 12'(768 + c), w);
        @(negedge clk);
        check_eq("pre_rst_level", 32'(bus.fifo_level), 3);
        check_eq("pre_rst_we", 32'(bus.ram_we), 1);
        #2 rst = 1'b1;
        bus.disp_active = 1'b0;
        #1;
        check_eq("mid_rst_we", 32'(bus.ram_we), 0);
        check_eq("mid_rst_level", 32'(bus.fifo_level), 0);
        check_eq("mid_rst_pixel", 32'(bus.disp_pixel), 0);
        check_eq("mid_rst_ready", 32'(bus.wr_ready), 0);
        check_eq("mid_rst_oob", 32'(bus.oob_err), 0);
        exp_q.delete();
        check_eq("mem_651", 32'(mem[651]), 32'(768 + 11));
        @(negedge clk);
        rst = 1'b0;
        check_eq("rel_ready0", 32'(bus.wr_ready), 0);
        @(negedge clk);
        check_eq("rel_ready1", 32'(bus.wr_ready), 1);
        check_eq("rel_level", 32'(bus.fifo_level), 0);
        repeat (4) @(negedge clk);
        check_eq("rel_quiet", 32'(count_we(cyc_cnt - 4, cyc_cnt - 1)), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
